// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver.
//   OVERSAMPLE : oversample ticks per bit period
//   rx_state_e : receiver FSM state encoding
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/baudrate_generator.sv
// baudrate_generator -- free-running single-cycle tick every
// CLK_FREQ/BAUD_RATE clocks (integer truncated).
//   clk   : clock
//   reset : async active-high reset
//   tick  : one-clk strobe per period
module baudrate_generator #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = (CLK_FREQ / BAUD_RATE < 1) ? 1 : CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 16x oversampling UART receiver, LSB first, M stop bits.
//   clk        : clock
//   reset      : async active-high reset
//   rx         : async serial line, idle high
//   data_out   : last received word (held until next data_valid)
//   data_valid : one-clk pulse at the last stop-bit sample
//   parity_err : even-parity mismatch for data_out
//   frame_err  : a stop-bit sample was low for data_out
//   busy       : start-bit detection until return to IDLE
// Build option: define UART_RX_PARITY_EN to receive and check one
// even-parity bit after the data bits; otherwise parity_err is tied 0.
// N must be at least 2.
module uart_rx
  import uart_pkg::*;
#(
  parameter int N         = 8,
  parameter int M         = 1,
  parameter int BAUD_RATE = 9600,
  parameter int CLK_FREQ  = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int BW = $clog2(N + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(N - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(M - 1);

  logic            rx_s1, rx_s2, rx_prev;
  logic            tick;
  rx_state_e       state;
  logic [3:0]      tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [N-1:0]    shift_reg;
  logic            frame_pend;
  logic            samp;

  baudrate_generator #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE * OVERSAMPLE)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Sampling point of DATA/PARITY/STOP bits: 16 ticks after the previous
  // sample, which starts at mid start bit, so every sample lands mid-bit.
  assign samp = tick && (tick_cnt == 4'd15);

`ifdef UART_RX_PARITY_EN
  logic parity_pend;
  logic parity_q;
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      frame_pend <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_pend <= 1'b0;
      parity_q    <= 1'b0;
`endif
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      data_valid <= 1'b0;

      case (state)
        IDLE: begin
          // Edge tracking runs every cycle, so a start bit arriving right
          // after a stop sample is caught on the first IDLE cycle.
          if (rx_prev && !rx_s2) begin
            state      <= START;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            frame_pend <= 1'b0;
            busy       <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_pend <= 1'b0;
`endif
          end
        end

        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              // Mid start bit: still low means a real frame, else a glitch.
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx_s2) begin
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) tick_cnt <= tick_cnt + 4'd1;
          if (samp) begin
            shift_reg <= {rx_s2, shift_reg[N-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) tick_cnt <= tick_cnt + 4'd1;
          if (samp) begin
            // Even parity: data bits plus parity bit must XOR to 0.
            parity_pend <= rx_s2 ^ (^shift_reg);
            bit_cnt     <= '0;
            state       <= STOP;
          end
        end
`endif

        STOP: begin
          if (tick) tick_cnt <= tick_cnt + 4'd1;
          if (samp) begin
            if (bit_cnt == LAST_STOP) begin
              data_out   <= shift_reg;
              frame_err  <= frame_pend | ~rx_s2;
              data_valid <= 1'b1;
              bit_cnt    <= '0;
              busy       <= 1'b0;
              state      <= IDLE;
`ifdef UART_RX_PARITY_EN
              parity_q   <= parity_pend;
`endif
            end else begin
              frame_pend <= frame_pend | ~rx_s2;
              bit_cnt    <= bit_cnt + BW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int N        = 8;
  localparam int M        = 1;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 9600;
  localparam int TICK     = 10;          // 1600000/153600 = 10.41 -> 10
  localparam int BIT      = 16 * TICK;   // 160 clk per bit
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 1 + N + 1 + M;
`else
  localparam int FRAME_BITS = 1 + N + M;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         rx;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  always #10 clk = ~clk;

  uart_rx #(
    .N         (N),
    .M         (M),
    .BAUD_RATE (BAUD),
    .CLK_FREQ  (CLK_FREQ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vtime[$];
  int   n_chk     = 0;
  int   n_fail    = 0;
  int   valid_cnt = 0;
  int   exp_valid = 0;
  int   cyc       = 0;
  logic dv_prev   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares every data_valid against the scoreboard head.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      valid_cnt++;
      vtime.push_back(cyc);
      check("dv_single_cycle", {31'b0, dv_prev}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", {24'b0, data_out}, {24'b0, mon_e.data});
        check("parity_err", {31'b0, parity_err}, {31'b0, mon_e.perr});
        check("frame_err", {31'b0, frame_err}, {31'b0, mon_e.ferr});
      end
    end
    dv_prev = data_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    sb.push_back(e);
    exp_valid++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit chk_busy);
    rx = 1'b0;
    wait_clks(BIT / 2);
    if (chk_busy) check("busy_in_frame", {31'b0, busy}, 32'd1);
    wait_clks(BIT - BIT / 2);
    for (int i = 0; i < N; i++) begin
      rx = d[i];
      wait_clks(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_clks(BIT);
`else
    if (par === 1'bz) wait_clks(1);
`endif
    for (int i = 0; i < M; i++) begin
      rx = stop;
      wait_clks(BIT);
    end
    rx = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (valid_cnt < exp_valid && k < 4 * BIT) begin
      wait_clks(1);
      k++;
    end
    check(name, valid_cnt, exp_valid);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data_out"}, {24'b0, data_out}, 32'd0);
    check({tag, "_data_valid"}, {31'b0, data_valid}, 32'd0);
    check({tag, "_parity_err"}, {31'b0, parity_err}, 32'd0);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int d;
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(2);
    check_idle_outputs("reset");
    wait_clks(BIT);

    // Basic frame, even-parity bit 0 (0xA5 has four ones).
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    wait_valid("valid_A5");
    wait_clks(2);
    check("busy_after_A5", {31'b0, busy}, 32'd0);
    wait_clks(BIT);

    // Start-bit glitch, 3 ticks low.
    rx = 1'b0;
    wait_clks(3 * TICK);
    check("busy_glitch", {31'b0, busy}, 32'd1);
    rx = 1'b1;
    wait_clks(2 * BIT);
    check("busy_after_glitch", {31'b0, busy}, 32'd0);
    check("no_valid_glitch", valid_cnt, 32'd1);
    check("hold_after_glitch", {24'b0, data_out}, 32'h0000_00A5);

    // Stop bit driven low.
    push_exp(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_valid("valid_3C");
    wait_clks(BIT);

`ifdef UART_RX_PARITY_EN
    push_exp(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_valid("valid_07_good_par");
    wait_clks(BIT);
    push_exp(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    wait_valid("valid_07_bad_par");
    wait_clks(BIT);
`endif

    // Reset during data bit 3 of 0x55 (bits 1,0,1 then 0).
    rx = 1'b0; wait_clks(BIT);
    rx = 1'b1; wait_clks(BIT);
    rx = 1'b0; wait_clks(BIT);
    rx = 1'b1; wait_clks(BIT);
    rx = 1'b0; wait_clks(BIT / 2);
    check("busy_before_reset", {31'b0, busy}, 32'd1);
    rx    = 1'b1;
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
    check_idle_outputs("midreset");
    wait_clks(2 * BIT);
    check("no_valid_midreset", valid_cnt, exp_valid);
    push_exp(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    wait_valid("valid_55");
    wait_clks(BIT);

    // Back-to-back frames, no idle gap.
    push_exp(8'h01, 1'b0, 1'b0);
    push_exp(8'hFE, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 1'b0);
    wait_valid("valid_b2b");
    if (vtime.size() >= 2) begin
      d = vtime[vtime.size() - 1] - vtime[vtime.size() - 2];
      check("b2b_spacing",
            {31'b0, (d >= FRAME_BITS * BIT - TICK) && (d <= FRAME_BITS * BIT + TICK)}, 32'd1);
    end else begin
      check("b2b_spacing_count", vtime.size(), 32'd2);
    end
    wait_clks(BIT);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter N, default 8, SHALL set the number of data bits per frame.
REQ-002 Parameter M, default 1, SHALL set the number of stop bits per frame.
REQ-003 Parameter BAUD_RATE, default 9600, SHALL set the line bit rate.
REQ-004 Parameter CLK_FREQ, default 50000000, SHALL set the clk frequency in Hz.
REQ-005 clk  input  1  SHALL be the single clock of the block.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-008 data_out  output  N  SHALL carry the last received word, LSB first on the line.
REQ-009 data_valid  output  1  SHALL pulse high for one clk when a frame completes.
REQ-010 parity_err  output  1  SHALL flag a parity mismatch for the word on data_out.
REQ-011 frame_err  output  1  SHALL flag a low stop-bit sample for the word on data_out.
REQ-012 busy  output  1  SHALL be high from start-bit detection until return to IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-014 An oversample tick SHALL occur every CLK_FREQ/(BAUD_RATE*16) clk, integer truncated.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: a synchronized 1->0 transition SHALL enter START, clear the 4-bit tick count and set busy.
REQ-017 START: at tick count 7 (mid start bit), rx=0 SHALL enter DATA; rx=1 SHALL return to IDLE with no data_valid (glitch reject).
REQ-018 DATA: every 16th tick SHALL sample rx into the shift register MSB, shifting right; after N samples SHALL enter PARITY if compiled in, else STOP.
REQ-019 PARITY: after 16 ticks SHALL sample rx and set the pending parity error to (sample != XOR of data bits), i.e. even parity.
REQ-020 STOP: SHALL sample M stop bits, 16 ticks apart; any 0 sample SHALL set the pending frame error.
REQ-021 After the last stop sample, data_out, parity_err and frame_err SHALL update and data_valid SHALL pulse on the same clk; FSM SHALL enter IDLE and clear busy.
REQ-022 data_out and error flags SHALL hold until the next data_valid; data_valid SHALL fire even on errored frames.
REQ-023 Tick count SHALL wrap 15->0; bit counter SHALL be $clog2(N+1) bits and clear on every state entry.
REQ-024 A new falling edge SHALL be accepted in the first IDLE cycle after a stop bit (back-to-back frames).

Reset
REQ-025 reset SHALL force state IDLE, counters 0, shift register 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-026 reset mid-frame SHALL discard the partial word with no data_valid.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined SHALL include the PARITY state and check one even-parity bit after data.
REQ-028 Macro UART_RX_PARITY_EN undefined SHALL remove the PARITY state; parity_err SHALL be tied 0 and DATA SHALL go directly to STOP.

Structure
REQ-029 Package uart_pkg SHALL hold the rx state enum typedef and the oversample factor constant (16).
REQ-030 The oversample tick SHALL come from one baudrate_generator instance with BAUD_RATE set to BAUD_RATE*16.

Verification (CLK_FREQ 50 MHz, BAUD_RATE 9600: tick = 325 clk, bit = 5200 clk)
REQ-031 Frame 0xA5, 1 stop bit -> data_out=0xA5, single-cycle data_valid near mid stop bit, both error flags 0, busy low afterwards.
REQ-032 rx low 975 clk (3 ticks) then high -> no data_valid, busy returns 0, FSM in IDLE.
REQ-033 Frame 0x3C with stop bit driven 0 -> data_valid with data_out=0x3C, frame_err=1.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1.
REQ-035 reset pulsed during DATA bit 3, then frame 0x55 -> all outputs 0 after reset, then data_out=0x55 with one data_valid.
REQ-036 Frames 0x01 then 0xFE with no idle gap -> two data_valid pulses 10 bit periods apart, data_out 0x01 then 0xFE.
